// File: rtl/washctrl_regfile_if.sv
// Host-side register bus for washctrl_regfile: strobes, shared address,
// write data, registered read data with valid, and write-reject pulse.
interface washctrl_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_enb;
  logic              rd_enb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_err;

  modport slave (
    input  wr_enb, rd_enb, addr, wr_data,
    output rd_data, rd_valid, wr_err
  );

  modport master (
    output wr_enb, rd_enb, addr, wr_data,
    input  rd_data, rd_valid, wr_err
  );
endinterface

// File: rtl/washctrl_regfile.sv
// Control/status register file for the washing-machine controller.
// Optional macro WASH_TIME_CLAMP_EN clamps WASH_TIME writes to [TIME_MIN, TIME_MAX].
module washctrl_regfile #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int PRESET_W     = 2,
  parameter int TIME_DEFAULT = 30,
  parameter int TIME_MIN     = 1,
  parameter int TIME_MAX     = 120
) (
  input  logic                clk,
  input  logic                rst,
  washctrl_regfile_if.slave   bus,
  input  logic                busy,
  input  logic                done,
  output logic                control_start,
  output logic                control_drying,
  output logic [PRESET_W-1:0] control_preset,
  output logic [DATA_W-1:0]   washing_time
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PRESET = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TIME   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [DATA_W-1:0] T_DEF = DATA_W'(TIME_DEFAULT);
  localparam logic [DATA_W-1:0] T_MIN = DATA_W'(TIME_MIN);
  localparam logic [DATA_W-1:0] T_MAX = DATA_W'(TIME_MAX);
`ifdef WASH_TIME_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] clamp_time(input logic [DATA_W-1:0] v);
    if (CLAMP_EN && (v < T_MIN)) return T_MIN;
    if (CLAMP_EN && (v > T_MAX)) return T_MAX;
    return v;
  endfunction

  logic                drying_q, drying_d;
  logic [PRESET_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0]   wtime_q, wtime_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                start_q, start_d;
  logic                wr_err_q, wr_err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   scratch_q [DEPTH];
  logic [DATA_W-1:0]   scratch_d [DEPTH];
  logic [DATA_W-1:0]   rd_mux;
  logic                wr_rej, wr_ok;

  // CTRL, PRESET and WASH_TIME are frozen while the sequencer runs
  assign wr_rej = bus.wr_enb & busy & (bus.addr < A_STATUS);
  assign wr_ok  = bus.wr_enb & ~wr_rej;

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      A_CTRL:   rd_mux = DATA_W'({drying_q, 1'b0});
      A_PRESET: rd_mux = DATA_W'(preset_q);
      A_TIME:   rd_mux = wtime_q;
      A_STATUS: rd_mux = DATA_W'({err_q, done_q, busy});
      default:  rd_mux = scratch_q[bus.addr];
    endcase
  end

  always_comb begin
    drying_d   = drying_q;
    preset_d   = preset_q;
    wtime_d    = wtime_q;
    done_d     = done_q;
    err_d      = err_q;
    scratch_d  = scratch_q;
    start_d    = 1'b0;
    wr_err_d   = wr_rej;
    rd_valid_d = bus.rd_enb;
    rd_data_d  = bus.rd_enb ? rd_mux : rd_data_q;
    if (wr_ok) begin
      case (bus.addr)
        A_CTRL: begin
          drying_d = bus.wr_data[1];
          start_d  = bus.wr_data[0];
        end
        A_PRESET: preset_d = bus.wr_data[PRESET_W-1:0];
        A_TIME:   wtime_d  = clamp_time(bus.wr_data);
        A_STATUS: begin
          if (bus.wr_data[1]) done_d = 1'b0;
          if (bus.wr_data[2]) err_d  = 1'b0;
        end
        default:  scratch_d[bus.addr] = bus.wr_data;
      endcase
    end
    // Sticky set beats a same-cycle W1C clear
    if (done)   done_d = 1'b1;
    if (wr_rej) err_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drying_q   <= 1'b0;
      preset_q   <= '0;
      wtime_q    <= T_DEF;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) scratch_q[i] <= '0;
    end else begin
      drying_q   <= drying_d;
      preset_q   <= preset_d;
      wtime_q    <= wtime_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= start_d;
      wr_err_q   <= wr_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      scratch_q  <= scratch_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.wr_err     = wr_err_q;
  assign control_start  = start_q;
  assign control_drying = drying_q;
  assign control_preset = preset_q;
  assign washing_time   = wtime_q;
endmodule
